decode_buffer: RTL and testbench

- Registered, parametrised RV32I decode stage between the instruction queue and dispatch.
- Decodes each instruction on acceptance and stores the decoded fields in a DEPTH-entry in-order FIFO.
- Head entry is presented to dispatch and RF, with stall rules per target unit, illegal-instruction flagging and flush on clear.
- Replaces the purely combinational decode that stalled on any unit being full.

---
 rtl/decode_buffer_if.sv | 60 ++++++
 rtl/decode_buffer.sv | 238 +++++++++++++++++++++++
 tb/tb_decode_buffer.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_buffer_if.sv
// decode_buffer_if
//   Bundles the instruction-queue, back-pressure, dispatch and register-file
//   signals of the decode buffer. Port names match the surrounding pipeline.
//
//   master : the pipeline side (IQ, RS/LSB/ROB, dispatch/RF consumers)
//   slave  : the decode buffer itself
//
//   Handshakes:
//   - IQ -> buffer: an instruction moves on a rising clk edge where IQ_flag
//     and Dec_ready are both high (with rdy_in=1 and clear_in=0). Dec_ready
//     never looks at IQ_flag or at the same-cycle dispatch. IQ holds
//     IQ_inst/IQ_PC/IQ_BTB_* stable until the transfer happens.
//   - buffer -> dispatch: Dis_flag high means the head entry is consumed on
//     this edge. RS_full/LSB_full/ROB_full act as the inverted ready of the
//     consumers, and Dis_flag is only raised when the targeted units can take
//     the entry.
interface decode_buffer_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int OP_W  = 6
);
  logic             IQ_flag;
  logic [31:0]      IQ_inst;
  logic [XLEN-1:0]  IQ_PC;
  logic [XLEN-1:0]  IQ_BTB_PC;
  logic             IQ_BTB_predict;
  logic             Dec_ready;
  logic             RS_full;
  logic             LSB_full;
  logic             ROB_full;
  logic             Dis_flag;
  logic [OP_W-1:0]  Dis_op;
  logic [REG_W-1:0] Dis_rd;
  logic [XLEN-1:0]  Dis_imm;
  logic [XLEN-1:0]  Dis_PC;
  logic [XLEN-1:0]  Dis_BTB_PC;
  logic             Dis_BTB_predict;
  logic             Dis_is_ls;
  logic             Dis_illegal;
  logic             RF_R1;
  logic             RF_R2;
  logic [REG_W-1:0] RF_rs1;
  logic [REG_W-1:0] RF_rs2;

  modport master (
    output IQ_flag, IQ_inst, IQ_PC, IQ_BTB_PC, IQ_BTB_predict,
    output RS_full, LSB_full, ROB_full,
    input  Dec_ready, Dis_flag, Dis_op, Dis_rd, Dis_imm, Dis_PC, Dis_BTB_PC,
    input  Dis_BTB_predict, Dis_is_ls, Dis_illegal,
    input  RF_R1, RF_R2, RF_rs1, RF_rs2
  );

  modport slave (
    input  IQ_flag, IQ_inst, IQ_PC, IQ_BTB_PC, IQ_BTB_predict,
    input  RS_full, LSB_full, ROB_full,
    output Dec_ready, Dis_flag, Dis_op, Dis_rd, Dis_imm, Dis_PC, Dis_BTB_PC,
    output Dis_BTB_predict, Dis_is_ls, Dis_illegal,
    output RF_R1, RF_R2, RF_rs1, RF_rs2
  );
endinterface

// File: rtl/decode_buffer.sv
// decode_buffer
//   RV32I decode stage: decodes each accepted instruction and stores the
//   decoded fields in a DEPTH-entry in-order FIFO. The head entry drives the
//   dispatch and register-file outputs; it leaves when its target units
//   (ROB plus RS or LSB) can accept it. Illegal encodings carry op=0 and
//   illegal=1 and only need ROB space.
//
//   clk_in   : clock (rising edge)
//   rst_in   : synchronous active-low reset, overrides everything
//   rdy_in   : global enable, 0 freezes all state
//   clear_in : flush (mispredict), empties the buffer, drops same-cycle push
//   bus      : IQ / back-pressure / dispatch / RF signals (slave view)
module decode_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int XLEN   = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 6
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           clear_in,
  decode_buffer_if.slave bus
);

  // Internal op codes; 0 is reserved for "none / illegal".
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(1),  OP_AUIPC = OP_W'(2),  OP_JAL  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(4),  OP_BEQ   = OP_W'(5),  OP_BNE  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(7),  OP_BGE   = OP_W'(8),  OP_BLTU = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(10), OP_LB    = OP_W'(11), OP_LH   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(13), OP_LBU   = OP_W'(14), OP_LHU  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_SB   = OP_W'(16), OP_SH    = OP_W'(17), OP_SW   = OP_W'(18);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(19), OP_SLTI  = OP_W'(20), OP_SLTIU = OP_W'(21);
  localparam logic [OP_W-1:0] OP_XORI = OP_W'(22), OP_ORI   = OP_W'(23), OP_ANDI = OP_W'(24);
  localparam logic [OP_W-1:0] OP_SLLI = OP_W'(25), OP_SRLI  = OP_W'(26), OP_SRAI = OP_W'(27);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(28), OP_SUB   = OP_W'(29), OP_SLL  = OP_W'(30);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(31), OP_SLTU  = OP_W'(32), OP_XOR  = OP_W'(33);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(34), OP_SRA   = OP_W'(35), OP_OR   = OP_W'(36);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(37);

  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6f, OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03, OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_OPIMM = 7'h13, OPC_OP = 7'h33;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             r1;
    logic             r2;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  btb_pc;
    logic             btb_pred;
    logic             is_ls;
    logic             illegal;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [ADDR_W-1:0] head_ptr;
  logic [ADDR_W-1:0] tail_ptr;
  logic [ADDR_W:0]   count;

  entry_t            dec;
  entry_t            shown;
  logic              legal;
  logic              ready;
  logic              push;
  logic              pop;
  logic              unit_ok;

  logic [31:0]       inst;
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [REG_W-1:0]  rd_f, rs1_f, rs2_f;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j;

  assign inst  = bus.IQ_inst;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign rd_f  = REG_W'(inst[11:7]);
  assign rs1_f = REG_W'(inst[19:15]);
  assign rs2_f = REG_W'(inst[24:20]);
  assign imm_i = {{(XLEN-11){inst[31]}}, inst[30:20]};
  assign imm_s = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
  assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  // Decode of the word currently offered by the IQ.
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opc)
      OPC_LUI:   begin dec.op = OP_LUI;   dec.rd = rd_f; dec.imm = imm_u; end
      OPC_AUIPC: begin dec.op = OP_AUIPC; dec.rd = rd_f; dec.imm = imm_u; end
      OPC_JAL:   begin dec.op = OP_JAL;   dec.rd = rd_f; dec.imm = imm_j; end
      OPC_JALR: begin
        dec.op = OP_JALR; dec.rd = rd_f; dec.rs1 = rs1_f; dec.r1 = 1'b1; dec.imm = imm_i;
      end
      OPC_BRANCH: begin
        dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.r1 = 1'b1; dec.r2 = 1'b1; dec.imm = imm_b;
        case (f3)
          3'b000:  dec.op = OP_BEQ;
          3'b001:  dec.op = OP_BNE;
          3'b100:  dec.op = OP_BLT;
          3'b101:  dec.op = OP_BGE;
          3'b110:  dec.op = OP_BLTU;
          3'b111:  dec.op = OP_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.r1 = 1'b1; dec.imm = imm_i; dec.is_ls = 1'b1;
        case (f3)
          3'b000:  dec.op = OP_LB;
          3'b001:  dec.op = OP_LH;
          3'b010:  dec.op = OP_LW;
          3'b100:  dec.op = OP_LBU;
          3'b101:  dec.op = OP_LHU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.r1 = 1'b1; dec.r2 = 1'b1;
        dec.imm = imm_s; dec.is_ls = 1'b1;
        case (f3)
          3'b000:  dec.op = OP_SB;
          3'b001:  dec.op = OP_SH;
          3'b010:  dec.op = OP_SW;
          default: legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.r1 = 1'b1; dec.imm = imm_i;
        case (f3)
          3'b000: dec.op = OP_ADDI;
          3'b010: dec.op = OP_SLTI;
          3'b011: dec.op = OP_SLTIU;
          3'b100: dec.op = OP_XORI;
          3'b110: dec.op = OP_ORI;
          3'b111: dec.op = OP_ANDI;
          3'b001: begin
            if (f7 == 7'h00) dec.op = OP_SLLI;
            else             legal = 1'b0;
          end
          default: begin  // 3'b101: shift right, funct7 selects logical/arith
            if (f7 == 7'h00)      dec.op = OP_SRLI;
            else if (f7 == 7'h20) dec.op = OP_SRAI;
            else                  legal = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.r1 = 1'b1; dec.r2 = 1'b1;
        if (f7 == 7'h00) begin
          case (f3)
            3'b000:  dec.op = OP_ADD;
            3'b001:  dec.op = OP_SLL;
            3'b010:  dec.op = OP_SLT;
            3'b011:  dec.op = OP_SLTU;
            3'b100:  dec.op = OP_XOR;
            3'b101:  dec.op = OP_SRL;
            3'b110:  dec.op = OP_OR;
            default: dec.op = OP_AND;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'b000) begin
          dec.op = OP_SUB;
        end else if (f7 == 7'h20 && f3 == 3'b101) begin
          dec.op = OP_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    // Undecodable words keep only the PCs and the illegal marker.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.pc       = bus.IQ_PC;
    dec.btb_pc   = bus.IQ_BTB_PC;
    dec.btb_pred = bus.IQ_BTB_predict;
  end

  // Ready only reflects occupancy, keeping IQ and dispatch combinationally apart.
  assign ready   = (count < (ADDR_W+1)'(DEPTH));
  assign push    = bus.IQ_flag && ready && rdy_in && !clear_in;

  assign shown   = (count != '0) ? mem[head_ptr] : '0;
  assign unit_ok = shown.illegal ? 1'b1 : (shown.is_ls ? !bus.LSB_full : !bus.RS_full);
  assign pop     = rdy_in && !clear_in && (count != '0) && !bus.ROB_full && unit_ok;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        head_ptr <= '0;
        tail_ptr <= '0;
        count    <= '0;
      end else begin
        if (push) tail_ptr <= tail_ptr + 1'b1;
        if (pop)  head_ptr <= head_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk_in) begin
    if (push) mem[tail_ptr] <= dec;
  end

  assign bus.Dec_ready       = ready;
  assign bus.Dis_flag        = pop;
  assign bus.Dis_op          = shown.op;
  assign bus.Dis_rd          = shown.rd;
  assign bus.Dis_imm         = shown.imm;
  assign bus.Dis_PC          = shown.pc;
  assign bus.Dis_BTB_PC      = shown.btb_pc;
  assign bus.Dis_BTB_predict = shown.btb_pred;
  assign bus.Dis_is_ls       = shown.is_ls;
  assign bus.Dis_illegal     = shown.illegal;
  assign bus.RF_R1           = shown.r1;
  assign bus.RF_R2           = shown.r2;
  assign bus.RF_rs1          = shown.rs1;
  assign bus.RF_rs2          = shown.rs2;

endmodule

// File: tb/tb_decode_buffer.sv
// tb_decode_buffer
//   Self-checking bench for decode_buffer. A reference model (a queue of
//   decoded entries plus a table of legal encodings) predicts every output
//   each cycle; directed scenarios are followed by a randomized phase.
module tb_decode_buffer;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int OP_W  = 6;

  localparam int C_ADDI = 19;
  localparam int C_ADD  = 28;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             r1;
    logic             r2;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  btb_pc;
    logic             btb_pred;
    logic             is_ls;
    logic             illegal;
  } model_t;
  localparam int ENT_W = $bits(model_t);

  // ---------------- clock / reset ----------------
  logic clk_in   = 1'b0;
  logic rst_in   = 1'b0;
  logic rdy_in   = 1'b0;
  logic clear_in = 1'b0;
  always #5 clk_in = ~clk_in;

  decode_buffer_if #(.XLEN(XLEN), .REG_W(REG_W), .OP_W(OP_W)) bus();

  decode_buffer #(.DEPTH(DEPTH), .ADDR_W(2), .XLEN(XLEN), .REG_W(REG_W), .OP_W(OP_W)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .clear_in(clear_in),
    .bus     (bus)
  );

  // ---------------- scoreboard state ----------------
  int               total = 0;
  int               bad   = 0;
  logic [ENT_W-1:0] exp_q[$];
  logic [31:0]      iq_q[$];
  logic [31:0]      pc_ctr;
  int               op_tab[int];
  logic             last_push;
  int               dut_dis = 0;
  int               d0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference decoder ----------------
  function automatic int enc_key(input int opc, input int f3, input int f7);
    return (opc << 10) | (f3 << 7) | f7;
  endfunction

  task automatic add_op(input int opc, input int f3, input int f7, input int code);
    op_tab[enc_key(opc, f3, f7)] = code;
  endtask

  task automatic build_table();
    int br[6] = '{0, 1, 4, 5, 6, 7};
    int ld[5] = '{0, 1, 2, 4, 5};
    int oi[6] = '{0, 2, 3, 4, 6, 7};
    int rr[8] = '{28, 30, 31, 32, 33, 34, 36, 37};
    add_op('h37, 0, 0, 1);
    add_op('h17, 0, 0, 2);
    add_op('h6f, 0, 0, 3);
    add_op('h67, 0, 0, 4);
    for (int i = 0; i < 6; i++) add_op('h63, br[i], 0, 5 + i);
    for (int i = 0; i < 5; i++) add_op('h03, ld[i], 0, 11 + i);
    for (int i = 0; i < 3; i++) add_op('h23, i, 0, 16 + i);
    for (int i = 0; i < 6; i++) add_op('h13, oi[i], 0, 19 + i);
    add_op('h13, 1, 'h00, 25);
    add_op('h13, 5, 'h00, 26);
    add_op('h13, 5, 'h20, 27);
    for (int i = 0; i < 8; i++) add_op('h33, i, 'h00, rr[i]);
    add_op('h33, 0, 'h20, 29);
    add_op('h33, 5, 'h20, 35);
  endtask

  function automatic model_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                        input logic [31:0] btb, input logic pred);
    model_t e;
    int opc, f3, f7, key, si;
    e = '0;
    e.pc = pc; e.btb_pc = btb; e.btb_pred = pred;
    opc = int'(inst[6:0]); f3 = int'(inst[14:12]); f7 = int'(inst[31:25]);
    si  = int'(inst);
    if (opc == 'h37 || opc == 'h17 || opc == 'h6f || opc == 'h67) key = enc_key(opc, 0, 0);
    else if (opc == 'h33 || (opc == 'h13 && (f3 == 1 || f3 == 5))) key = enc_key(opc, f3, f7);
    else key = enc_key(opc, f3, 0);
    if (!op_tab.exists(key)) begin
      e.illegal = 1'b1;
      return e;
    end
    e.op = OP_W'(op_tab[key]);
    case (opc)
      'h37, 'h17: begin e.rd = inst[11:7]; e.imm = inst & 32'hFFFFF000; end
      'h6f: begin
        e.rd  = inst[11:7];
        e.imm = ((si >>> 31) << 20) | (int'(inst[19:12]) << 12) | (int'(inst[20]) << 11)
              | (int'(inst[30:21]) << 1);
      end
      'h67, 'h03, 'h13: begin
        e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.r1 = 1'b1; e.imm = si >>> 20;
      end
      'h63: begin
        e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.r1 = 1'b1; e.r2 = 1'b1;
        e.imm = ((si >>> 31) << 12) | (int'(inst[7]) << 11) | (int'(inst[30:25]) << 5)
              | (int'(inst[11:8]) << 1);
      end
      'h23: begin
        e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.r1 = 1'b1; e.r2 = 1'b1;
        e.imm = ((si >>> 25) << 5) | int'(inst[11:7]);
      end
      default: begin  // 'h33
        e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.r1 = 1'b1; e.r2 = 1'b1;
      end
    endcase
    e.is_ls = (opc == 'h03 || opc == 'h23);
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [6:0]  opcs [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 7) != 0) begin
      w[6:0] = opcs[$urandom_range(0, 8)];
      if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
        w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  // Called after a negedge with inputs applied: compares every output with
  // the model, advances the model as the coming edge will, then waits for it.
  task automatic step();
    model_t h;
    logic   exp_rdy, exp_dis, unit_ok, push;
    #1;
    h = '0;
    if (exp_q.size() > 0) h = model_t'(exp_q[0]);
    exp_rdy = (exp_q.size() < DEPTH);
    unit_ok = h.illegal ? 1'b1 : (h.is_ls ? !bus.LSB_full : !bus.RS_full);
    exp_dis = rdy_in && !clear_in && (exp_q.size() > 0) && !bus.ROB_full && unit_ok;
    check("dec_ready", bus.Dec_ready, exp_rdy);
    check("dis_flag", bus.Dis_flag, exp_dis);
    check("dis_op", bus.Dis_op, h.op);
    check("dis_rd", bus.Dis_rd, h.rd);
    check("dis_imm", bus.Dis_imm, h.imm);
    check("dis_pc", bus.Dis_PC, h.pc);
    check("dis_btb_pc", bus.Dis_BTB_PC, h.btb_pc);
    check("dis_btb_pred", bus.Dis_BTB_predict, h.btb_pred);
    check("dis_is_ls", bus.Dis_is_ls, h.is_ls);
    check("dis_illegal", bus.Dis_illegal, h.illegal);
    check("rf_r1", bus.RF_R1, h.r1);
    check("rf_r2", bus.RF_R2, h.r2);
    check("rf_rs1", bus.RF_rs1, h.rs1);
    check("rf_rs2", bus.RF_rs2, h.rs2);
    if (bus.Dis_flag === 1'b1) dut_dis++;
    push      = bus.IQ_flag && exp_rdy && rdy_in && !clear_in;
    last_push = 1'b0;
    if (!rst_in) begin
      exp_q.delete();
    end else if (rdy_in) begin
      if (clear_in) begin
        exp_q.delete();
      end else begin
        if (exp_dis) void'(exp_q.pop_front());
        if (push) begin
          exp_q.push_back(ref_decode(bus.IQ_inst, bus.IQ_PC, bus.IQ_BTB_PC, bus.IQ_BTB_predict));
          last_push = 1'b1;
        end
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Behaves like the IQ: offers the head of iq_q until it is accepted.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (iq_q.size() > 0) begin
        bus.IQ_flag = 1'b1;
        bus.IQ_inst = iq_q[0];
      end else begin
        bus.IQ_flag = 1'b0;
        bus.IQ_inst = $urandom();
      end
      bus.IQ_PC          = pc_ctr;
      bus.IQ_BTB_PC      = $urandom();
      bus.IQ_BTB_predict = 1'($urandom_range(0, 1));
      step();
      if (last_push) begin
        void'(iq_q.pop_front());
        pc_ctr += 32'd4;
      end
    end
  endtask

  task automatic load_iq(input int n);
    for (int i = 0; i < n; i++) iq_q.push_back(gen_inst());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    build_table();
    bus.IQ_flag = 1'b0; bus.IQ_inst = '0; bus.IQ_PC = '0; bus.IQ_BTB_PC = '0;
    bus.IQ_BTB_predict = 1'b0;
    bus.RS_full = 1'b0; bus.LSB_full = 1'b0; bus.ROB_full = 1'b0;
    pc_ctr = 32'h100;
    rst_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    rdy_in = 1'b1;

    // 1: single addi through an empty buffer
    iq_q.push_back(32'hFFF00293);
    run(1);
    check("t1_flag", bus.Dis_flag, 1);
    check("t1_op", bus.Dis_op, C_ADDI);
    check("t1_rd", bus.Dis_rd, 5);
    check("t1_imm", bus.Dis_imm, 32'hFFFFFFFF);
    check("t1_r1", bus.RF_R1, 1);
    check("t1_rs1", bus.RF_rs1, 0);
    check("t1_r2", bus.RF_R2, 0);
    check("t1_pc", bus.Dis_PC, 32'h100);
    run(1);
    check("t1_flag_after", bus.Dis_flag, 0);

    // 2: fill under ROB_full, fifth held, then drain in order
    bus.ROB_full = 1'b1;
    load_iq(5);
    run(4);
    check("t2_full", bus.Dec_ready, 0);
    run(2);
    bus.ROB_full = 1'b0;
    d0 = dut_dis;
    run(8);
    check("t2_drained", dut_dis - d0, 5);

    // 3: store blocked by LSB_full also blocks the add behind it
    bus.LSB_full = 1'b1;
    iq_q.push_back(32'h0020A423);
    iq_q.push_back(32'h002081B3);
    run(4);
    check("t3_stall", bus.Dis_flag, 0);
    bus.LSB_full = 1'b0;
    #1;
    check("t3_sw_flag", bus.Dis_flag, 1);
    check("t3_sw_ls", bus.Dis_is_ls, 1);
    check("t3_sw_imm", bus.Dis_imm, 8);
    check("t3_sw_rs1", bus.RF_rs1, 1);
    check("t3_sw_rs2", bus.RF_rs2, 2);
    check("t3_sw_r12", {bus.RF_R1, bus.RF_R2}, 2'b11);
    run(1);
    check("t3_add_flag", bus.Dis_flag, 1);
    check("t3_add_op", bus.Dis_op, C_ADD);
    run(1);

    // 4: clear with a simultaneous push
    bus.ROB_full = 1'b1;
    load_iq(3);
    run(3);
    clear_in = 1'b1;
    bus.IQ_flag = 1'b1;
    bus.IQ_inst = 32'hFFF00293;
    step();
    clear_in = 1'b0;
    bus.IQ_flag = 1'b0;
    bus.ROB_full = 1'b0;
    #1;
    check("t4_flag", bus.Dis_flag, 0);
    check("t4_ready", bus.Dec_ready, 1);
    check("t4_op", bus.Dis_op, 0);
    run(2);

    // 5: illegal entries bypass RS_full but not ROB_full
    bus.RS_full = 1'b1;
    iq_q.push_back(32'h00000000);
    iq_q.push_back(32'h02208033);
    run(1);
    check("t5_illegal", bus.Dis_illegal, 1);
    check("t5_op", bus.Dis_op, 0);
    check("t5_r12", {bus.RF_R1, bus.RF_R2}, 2'b00);
    check("t5_flag", bus.Dis_flag, 1);
    d0 = dut_dis;
    run(3);
    check("t5_count", dut_dis - d0, 2);
    bus.ROB_full = 1'b1;
    iq_q.push_back(32'hFFFFFFFF);
    run(3);
    check("t5_rob_hold", bus.Dis_flag, 0);
    check("t5_rob_illegal", bus.Dis_illegal, 1);
    bus.ROB_full = 1'b0;
    bus.RS_full = 1'b0;
    run(2);

    // 6: stream of 10 with a freeze in the middle, then reset with entries held
    load_iq(10);
    d0 = dut_dis;
    run(5);
    rdy_in = 1'b0;
    run(3);
    rdy_in = 1'b1;
    run(12);
    check("t6_streamed", dut_dis - d0, 10);
    bus.ROB_full = 1'b1;
    load_iq(2);
    run(2);
    rst_in = 1'b0;
    bus.IQ_flag = 1'b1;
    clear_in = 1'b1;
    step();
    rst_in = 1'b1;
    clear_in = 1'b0;
    bus.IQ_flag = 1'b0;
    bus.ROB_full = 1'b0;
    #1;
    check("t6_rst_ready", bus.Dec_ready, 1);
    check("t6_rst_flag", bus.Dis_flag, 0);
    check("t6_rst_op", bus.Dis_op, 0);
    check("t6_rst_pc", bus.Dis_PC, 0);
    check("t6_rst_r1", bus.RF_R1, 0);
    run(2);

    // random phase
    for (int i = 0; i < 400; i++) begin
      rdy_in       = ($urandom_range(0, 9) != 0);
      clear_in     = ($urandom_range(0, 24) == 0);
      rst_in       = ($urandom_range(0, 59) != 0);
      bus.RS_full  = ($urandom_range(0, 3) == 0);
      bus.LSB_full = ($urandom_range(0, 3) == 0);
      bus.ROB_full = ($urandom_range(0, 4) == 0);
      if (iq_q.size() < 2 && $urandom_range(0, 3) != 0) load_iq($urandom_range(1, 4));
      run(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
